// File: rtl/xorshift_multi_gen.sv
// Multi-channel xorshift traffic source: NUM_CH seeded generators feed private FIFOs,
// merged round-robin onto one valid/ready stream tagged with the source channel.
module xorshift_multi_gen #(
  parameter int              CPU_INDEX  = 0,
  parameter int              NUM_CH     = 4,
  parameter int              DATA_W     = 64,
  parameter int              NUM_TRANS  = 1000,
  parameter int              FIFO_DEPTH = 4,
  parameter longint unsigned SEED       = 64'd1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  output logic                                           out_vld,
  input  logic                                           out_rdy,
  output logic [DATA_W-1:0]                              out_data,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
  output logic                                           busy,
  output logic                                           transactions_done
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(NUM_TRANS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [DATA_W-1:0] x_r      [NUM_CH];
  logic [DATA_W-1:0] x_nxt_s  [NUM_CH];
  logic [CNT_W-1:0]  cnt_r    [NUM_CH];
  logic [DATA_W-1:0] mem_r    [NUM_CH][FIFO_DEPTH];
  logic [AW:0]       wr_ptr_r [NUM_CH];
  logic [AW:0]       rd_ptr_r [NUM_CH];
  logic [NUM_CH-1:0] empty_s, full_s, push_s, pop_s, cnt_done_s;
  logic              start_go_s, load_s, grant_vld_s;
  logic [CH_W-1:0]   grant_s, rr_r, rr_nxt_s;
  logic [DATA_W-1:0] head_s;
  logic              out_vld_r, busy_r, done_r;
  logic [DATA_W-1:0] out_data_r;
  logic [CH_W-1:0]   out_ch_r;

  // One xorshift step; the shift triple is chosen by word width.
  function automatic logic [DATA_W-1:0] xs_step(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] t;
    if (DATA_W == 32) begin
      t = x ^ (x << 13);
      t = t ^ (t >> 17);
      t = t ^ (t << 5);
    end else begin
      t = x ^ (x << 13);
      t = t ^ (t >> 7);
      t = t ^ (t << 17);
    end
    return t;
  endfunction

  // Per-channel seed; xorshift has a fixed point at zero, so zero becomes one.
  function automatic logic [DATA_W-1:0] seed_of(input int c);
    logic [DATA_W-1:0] s;
    s = DATA_W'(SEED) + DATA_W'(CPU_INDEX * NUM_CH) + DATA_W'(c) + DATA_W'(1'b1);
    if (s == {DATA_W{1'b0}}) begin
      s = DATA_W'(1'b1);
    end else begin
      s = s;
    end
    return s;
  endfunction

  assign start_go_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign load_s     = !out_vld_r || out_rdy;

  // Per-channel FIFO flags, next generator state and push enables.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      x_nxt_s[c]    = xs_step(x_r[c]);
      empty_s[c]    = (wr_ptr_r[c] == rd_ptr_r[c]);
      full_s[c]     = (wr_ptr_r[c][AW] != rd_ptr_r[c][AW]) &&
                      (wr_ptr_r[c][AW-1:0] == rd_ptr_r[c][AW-1:0]);
      cnt_done_s[c] = (cnt_r[c] == CNT_W'(NUM_TRANS));
      push_s[c]     = (state_r == ST_RUN) && !cnt_done_s[c] && !full_s[c];
    end
  end

  // Round-robin grant: search from the pointer upward, then wrap to the lowest channel.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_s     = {CH_W{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      if (!grant_vld_s && (CH_W'(c) >= rr_r) && !empty_s[c]) begin
        grant_vld_s = 1'b1;
        grant_s     = CH_W'(c);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!grant_vld_s && !empty_s[c]) begin
        grant_vld_s = 1'b1;
        grant_s     = CH_W'(c);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
    if (grant_s == CH_W'(NUM_CH - 1)) begin
      rr_nxt_s = {CH_W{1'b0}};
    end else begin
      rr_nxt_s = grant_s + CH_W'(1'b1);
    end
  end

  // Head-of-FIFO mux for the granted channel and the matching pop strobe.
  always_comb begin
    head_s = {DATA_W{1'b0}};
    pop_s  = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_s == CH_W'(c)) begin
        head_s   = mem_r[c][rd_ptr_r[c][AW-1:0]];
        pop_s[c] = load_s && grant_vld_s;
      end else begin
        pop_s[c] = 1'b0;
      end
    end
  end

  // Generator state, word counters and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        x_r[c]      <= {DATA_W{1'b0}};
        cnt_r[c]    <= {CNT_W{1'b0}};
        wr_ptr_r[c] <= {(AW+1){1'b0}};
        rd_ptr_r[c] <= {(AW+1){1'b0}};
      end
    end else if (start_go_s) begin
      for (int c = 0; c < NUM_CH; c++) begin
        x_r[c]      <= seed_of(c);
        cnt_r[c]    <= {CNT_W{1'b0}};
        wr_ptr_r[c] <= {(AW+1){1'b0}};
        rd_ptr_r[c] <= {(AW+1){1'b0}};
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push_s[c]) begin
          x_r[c]      <= x_nxt_s[c];
          cnt_r[c]    <= cnt_r[c] + CNT_W'(1'b1);
          wr_ptr_r[c] <= wr_ptr_r[c] + (AW+1)'(1'b1);
        end
        if (pop_s[c]) begin
          rd_ptr_r[c] <= rd_ptr_r[c] + (AW+1)'(1'b1);
        end
      end
    end
  end

  // FIFO storage; the pushed word is the new generator state.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_s[c]) begin
        mem_r[c][wr_ptr_r[c][AW-1:0]] <= x_nxt_s[c];
      end
    end
  end

  // Output register and round-robin pointer; holds data while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_r  <= 1'b0;
      out_data_r <= {DATA_W{1'b0}};
      out_ch_r   <= {CH_W{1'b0}};
      rr_r       <= {CH_W{1'b0}};
    end else if (start_go_s) begin
      out_vld_r  <= 1'b0;
      rr_r       <= {CH_W{1'b0}};
    end else if (load_s) begin
      if (grant_vld_s) begin
        out_vld_r  <= 1'b1;
        out_data_r <= head_s;
        out_ch_r   <= grant_s;
        rr_r       <= rr_nxt_s;
      end else begin
        out_vld_r  <= 1'b0;
      end
    end
  end

  // Run-control next state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (&cnt_done_s) state_s = ST_DRAIN;
        else             state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if ((&empty_s) && load_s) state_s = ST_DONE;
        else                      state_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register with status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
      done_r  <= (state_s == ST_DONE);
    end
  end

  assign out_vld           = out_vld_r;
  assign out_data          = out_data_r;
  assign out_ch            = out_ch_r;
  assign busy              = busy_r;
  assign transactions_done = done_r;

endmodule

// File: tb/tb_xorshift_multi_gen.sv
// Bench for xorshift_multi_gen: two single-word instances for the known-answer words and
// latency, plus a 4-channel instance checked against a per-channel software model.
module tb_xorshift_multi_gen;

  localparam int NC    = 4;
  localparam int NT    = 12;
  localparam int TOTAL = NC * NT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, rst_m, start_m, rdy_m;
  logic        vld32, busy32, done32, vld64, busy64, done64;
  logic [31:0] data32;
  logic [63:0] data64;
  logic [0:0]  ch32, ch64;
  logic        vld_m, busy_m, done_m;
  logic [63:0] data_m;
  logic [1:0]  ch_m;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_w [NC][NT];

  xorshift_multi_gen #(.CPU_INDEX(0), .NUM_CH(1), .DATA_W(32), .NUM_TRANS(1),
                       .FIFO_DEPTH(2), .SEED(64'd0)) dut32 (
    .clk(clk), .rst(rst_a), .start(start_a), .out_vld(vld32), .out_rdy(1'b1),
    .out_data(data32), .out_ch(ch32), .busy(busy32), .transactions_done(done32));

  xorshift_multi_gen #(.CPU_INDEX(0), .NUM_CH(1), .DATA_W(64), .NUM_TRANS(1),
                       .FIFO_DEPTH(4), .SEED(64'd0)) dut64 (
    .clk(clk), .rst(rst_a), .start(start_a), .out_vld(vld64), .out_rdy(1'b1),
    .out_data(data64), .out_ch(ch64), .busy(busy64), .transactions_done(done64));

  xorshift_multi_gen #(.CPU_INDEX(1), .NUM_CH(NC), .DATA_W(64), .NUM_TRANS(NT),
                       .FIFO_DEPTH(4), .SEED(64'd5)) dut (
    .clk(clk), .rst(rst_m), .start(start_m), .out_vld(vld_m), .out_rdy(rdy_m),
    .out_data(data_m), .out_ch(ch_m), .busy(busy_m), .transactions_done(done_m));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] xs64(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  // Starts a run on the 4-channel instance and scores every accepted word.
  task automatic run_main(input int rdy_pct, input int pulse_at);
    int   idx [NC];
    int   accepted;
    bit   pv, pr, finished;
    logic [63:0] pd;
    logic [1:0]  pc;
    for (int c = 0; c < NC; c++) idx[c] = 0;
    accepted = 0; pv = 1'b0; pr = 1'b0; finished = 1'b0; pd = 64'd0; pc = 2'd0;
    @(negedge clk);
    start_m = 1'b1;
    rdy_m   = 1'b1;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      start_m = (cyc == pulse_at);
      rdy_m   = ($urandom_range(0, 99) < rdy_pct);
      if (accepted == TOTAL) begin
        check("done_flag", 64'(done_m), 64'd1);
        check("done_busy", 64'(busy_m), 64'd0);
        check("done_vld",  64'(vld_m),  64'd0);
        finished = 1'b1;
      end else begin
        check("busy_run", 64'(busy_m), 64'd1);
        check("done_low", 64'(done_m), 64'd0);
        if (cyc <= 2) check("latency", 64'(vld_m), 64'(cyc == 2));
        if (pv && !pr) begin
          check("hold_vld",  64'(vld_m), 64'd1);
          check("hold_data", data_m, pd);
          check("hold_ch",   64'(ch_m), 64'(pc));
        end
        if (rdy_pct == 100 && cyc >= 2) check("no_idle", 64'(vld_m), 64'd1);
        if (vld_m && rdy_m) begin
          if (rdy_pct == 100) check("rr_order", 64'(ch_m), 64'(accepted % NC));
          if (idx[ch_m] < NT) begin
            check("data", data_m, exp_w[ch_m][idx[ch_m]]);
            idx[ch_m]++;
          end else begin
            check("duplicate", 64'(idx[ch_m]), 64'(NT - 1));
          end
          accepted++;
        end
        pv = vld_m; pr = rdy_m; pd = data_m; pc = ch_m;
      end
    end
    check("finished", 64'(finished), 64'd1);
    for (int c = 0; c < NC; c++) check("per_ch_count", 64'(idx[c]), 64'(NT));
    start_m = 1'b0;
    rdy_m   = 1'b1;
  endtask

  initial begin
    logic [63:0] x;
    // Channel c seed = SEED + CPU_INDEX*NUM_CH + c + 1 = 10 + c.
    for (int c = 0; c < NC; c++) begin
      x = 64'(10 + c);
      for (int k = 0; k < NT; k++) begin
        x = xs64(x);
        exp_w[c][k] = x;
      end
    end

    rst_a = 1'b1; rst_m = 1'b1; start_a = 1'b0; start_m = 1'b0; rdy_m = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_m = 1'b0;
    @(negedge clk);
    check("rst_vld",  64'(vld_m),  64'd0);
    check("rst_data", data_m,      64'd0);
    check("rst_ch",   64'(ch_m),   64'd0);
    check("rst_busy", 64'(busy_m), 64'd0);
    check("rst_done", 64'(done_m), 64'd0);
    check("rst_vld32", 64'(vld32), 64'd0);

    // Single-word known answers and start-to-valid latency.
    for (int rep = 0; rep < 2; rep++) begin
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check("kat_e0_vld32", 64'(vld32), 64'd0);
      check("kat_e0_vld64", 64'(vld64), 64'd0);
      check("kat_e0_busy",  64'(busy64), 64'd1);
      @(negedge clk);
      check("kat_e1_vld32", 64'(vld32), 64'd0);
      check("kat_e1_vld64", 64'(vld64), 64'd0);
      @(negedge clk);
      check("kat_e2_vld32",  64'(vld32),  64'd1);
      check("kat_e2_data32", 64'(data32), 64'h0000_0000_0004_2021);
      check("kat_e2_ch32",   64'(ch32),   64'd0);
      check("kat_e2_vld64",  64'(vld64),  64'd1);
      check("kat_e2_data64", data64,      64'h0000_0000_4082_2041);
      @(negedge clk);
      check("kat_done32", 64'(done32), 64'd1);
      check("kat_done64", 64'(done64), 64'd1);
      check("kat_vld_off", 64'(vld32 | vld64), 64'd0);
      check("kat_busy_off", 64'(busy32 | busy64), 64'd0);
      @(negedge clk);
    end

    // Full throughput with an ignored start pulse mid-run.
    run_main(100, 6);
    // Replay from DONE with a 30% ready duty cycle.
    run_main(30, -1);

    // Abort mid-run with reset, then rerun from the first seeded values.
    @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    repeat (8) @(negedge clk);
    rst_m = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_vld",  64'(vld_m),  64'd0);
    check("abort_data", data_m,      64'd0);
    check("abort_ch",   64'(ch_m),   64'd0);
    check("abort_busy", 64'(busy_m), 64'd0);
    check("abort_done", 64'(done_m), 64'd0);
    rst_m = 1'b0;
    @(negedge clk);
    check("idle_done", 64'(done_m), 64'd0);
    run_main(100, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
